pce_rom_loader: RTL and testbench
=================================

// Module: pce_rom_loader
// PURPOSE
//  Converts the HPS ioctl download stream into 16-bit ROM write requests for the DDR3 and SDRAM
//  ROM controllers, and holds off the HPS until both controllers acknowledge each write.
//  Sits directly upstream of ddram/sdram: wr_addr/wr_data/wr_req feed their write ports.
//  Also produces the per-cartridge facts derived during load: ROM size, 512-byte header
//  presence, Populous mapper detection and the SuperGrafx flag consumed by pce_top.
// PARAMETERS
//  AW        24      width of wr_addr (byte address)
//  SGX_IDX   5'd2    ioctl_index[4:0] value that marks a SuperGrafx image
// PORTS
//  clk_sys         in   1    system clock; all logic on rising edge
//  reset           in   1    synchronous, active-high
//  ioctl_download  in   1    HPS download window
//  ioctl_index     in   8    image type selector
//  ioctl_wr        in   1    one-cycle strobe: ioctl_dout valid
//  ioctl_dout      in   16   ROM word, little-endian byte order
//  ioctl_wait      out  1    hold-off to HPS while a write is outstanding
//  swap            in   1    1 = bit-reverse each byte (ROM Data Swap option)
//  wr_addr         out  AW   byte address of current word (always even)
//  wr_data         out  16   word after optional bit reversal
//  wr_req          out  1    toggle request; one edge per word
//  ack_dd, ack_sd  in   1    toggle acks from ddram and sdram
//  rom_size        out  8    wr_addr[23:16], valid after download ends
//  hdr             out  1    wr_addr[9]: 512-byte header present
//  populous        out  1    Populous signature found at header-adjusted location
//  sgx             out  1    SuperGrafx image
// BEHAVIOUR
//  - Power-up values: wr_addr=0, wr_req=0, ioctl_wait=0, pop_flags=2'b00, sgx=0, state IDLE.
//  - reset: state->IDLE, ioctl_wait->0. wr_addr, wr_req, pop_flags, sgx untouched
//    (the ROM identity survives a console reset; the controllers complete in-flight toggles).
//  - FSM IDLE -> WAIT_WR on ioctl_download rising edge: wr_addr<=0, pop_flags<=2'b11,
//    sgx<=(ioctl_index[4:0]==SGX_IDX). A rise coinciding with ioctl_wr drops that write.
//  - WAIT_WR: on ioctl_wr: wr_req<=~wr_req, ioctl_wait<=1 in the same edge, run signature
//    check, go WAIT_ACK. ioctl_download low -> IDLE.
//  - WAIT_ACK: when wr_req==ack_dd && wr_req==ack_sd: ioctl_wait<=0, wr_addr<=wr_addr+2,
//    go WAIT_WR (IDLE if ioctl_download already low). ioctl_wr here is a protocol error: ignored.
//    Minimum turnaround: ioctl_wr edge -> ioctl_wait high 1 cycle; ack match -> wait low 1 cycle.
//  - wr_data combinational from ioctl_dout and swap; swap = each byte bit-reversed in place.
//  - Signature: if wr_addr[23:4] is 'h1F2 or 'h212, compare wr_data by wr_addr[3:0]:
//    6:'h4F50 8:'h5550 10:'h4F4C 12:'h5355; mismatch clears pop_flags[wr_addr[13]].
//    Other offsets ignored. populous = pop_flags[wr_addr[9]].
//  - wr_addr wraps at 2^AW silently; rom_size/hdr meaningful only after a complete load.
//  - Short file (< 'h2130 bytes): both lines never checked; flag stays 1 only if header
//    bit selects an unchecked line -> populous forced 0 when wr_addr < 'h1F30 at end.
// STRUCTURE
//  - pce_loader_pkg: state enum {IDLE,WAIT_WR,WAIT_ACK}, POP_SIG[4] words, POP_LINE_NOHDR
//    'h1F2, POP_LINE_HDR 'h212, bitrev8 function.
//  - One sub-module natural: pce_pop_sig_detect (address/data compare -> 2 clear strobes).
// TESTING
//  1 Load 4 words, acks mirror wr_req after 3 cycles -> wr_addr 0,2,4,6 then 8; wait
//    high 4 cycles per word; wr_req toggles 4 times.
//  2 ack_dd prompt, ack_sd 20 cycles late -> ioctl_wait stays high until ack_sd matches.
//  3 Headerless image with "POPULOUS" at 'h1F26..'h1F2D, size 'h40000 -> populous=1,
//    hdr=0, rom_size=8'h04; repeat with header at 'h2126 -> populous=1, hdr=1.
//  4 swap=1, ioctl_dout='h0180 -> wr_data='h8001.
//  5 ioctl_index=2 -> sgx=1; new download ioctl_index=1 -> sgx=0, wr_addr back to 0.
//  6 reset pulsed in WAIT_ACK -> ioctl_wait 0 next cycle, wr_addr unchanged, state IDLE.

Source files
------------

// File: rtl/pce_rom_loader_pkg.sv
// Shared types and constants for the PCE ROM loader: FSM states, Populous
// signature words and the per-byte bit reversal used by the ROM data swap option.
package pce_loader_pkg;

  typedef enum logic [1:0] {IDLE, WAIT_WR, WAIT_ACK} state_t;

  // Index 0 is the word at line offset 6 ("PO"), then "PU", "LO", "US".
  localparam logic [3:0][15:0] POP_SIG = {16'h5355, 16'h4F4C, 16'h5550, 16'h4F50};

  localparam logic [19:0] POP_LINE_NOHDR = 20'h1F2;
  localparam logic [19:0] POP_LINE_HDR   = 20'h212;

  function automatic logic [7:0] bitrev8(input logic [7:0] b);
    logic [7:0] r;
    for (int unsigned i = 0; i < 8; i++) r[i] = b[3'(7 - i)];
    return r;
  endfunction

endpackage

// File: rtl/pce_pop_sig_detect.sv
// Compares a ROM write against the Populous signature; raises a clear strobe
// for the flag of the line (bit 13 selects header/no-header) that mismatched.
module pce_pop_sig_detect
  import pce_loader_pkg::*;
#(
  parameter int AW = 24
) (
  input  logic [AW-1:0] i_addr,
  input  logic [15:0]   i_data,
  output logic [1:0]    o_clr
);

  logic        w_line_hit;
  logic        w_chk;
  logic [15:0] w_exp;

  assign w_line_hit = (i_addr[AW-1:4] == (AW-4)'(POP_LINE_NOHDR)) ||
                      (i_addr[AW-1:4] == (AW-4)'(POP_LINE_HDR));

  always_comb begin
    w_chk = 1'b1;
    w_exp = '0;
    case (i_addr[3:0])
      4'd6:    w_exp = POP_SIG[0];
      4'd8:    w_exp = POP_SIG[1];
      4'd10:   w_exp = POP_SIG[2];
      4'd12:   w_exp = POP_SIG[3];
      default: w_chk = 1'b0;
    endcase
    o_clr = '0;
    if (w_line_hit && w_chk && (i_data != w_exp)) o_clr[i_addr[13]] = 1'b1;
  end

endmodule

// File: rtl/pce_rom_loader.sv
// HPS ioctl download to 16-bit toggle-handshake ROM writes for ddram/sdram,
// plus cartridge facts (size, header, Populous mapper, SuperGrafx).
module pce_rom_loader
  import pce_loader_pkg::*;
#(
  parameter int         AW      = 24,
  parameter logic [4:0] SGX_IDX = 5'd2
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          ioctl_download,
  input  logic [7:0]    ioctl_index,
  input  logic          ioctl_wr,
  input  logic [15:0]   ioctl_dout,
  output logic          ioctl_wait,
  input  logic          swap,
  output logic [AW-1:0] wr_addr,
  output logic [15:0]   wr_data,
  output logic          wr_req,
  input  logic          ack_dd,
  input  logic          ack_sd,
  output logic [7:0]    rom_size,
  output logic          hdr,
  output logic          populous,
  output logic          sgx
);

  // Power-up values only: reset deliberately leaves the ROM identity and the
  // request toggle alone so in-flight controller handshakes stay coherent.
  state_t        r_state = IDLE;
  logic [AW-1:0] r_addr  = '0;
  logic          r_req   = 1'b0;
  logic          r_wait  = 1'b0;
  logic          r_dl_d  = 1'b0;
  logic          r_sgx   = 1'b0;
  logic [1:0]    r_pop   = '0;

  logic [1:0]    w_clr;
  logic          w_unused_idx;

  assign w_unused_idx = ^ioctl_index[7:5];

  assign wr_data = swap ? {bitrev8(ioctl_dout[15:8]), bitrev8(ioctl_dout[7:0])} : ioctl_dout;

  pce_pop_sig_detect #(.AW(AW)) u_sig (
    .i_addr (r_addr),
    .i_data (wr_data),
    .o_clr  (w_clr)
  );

  always_ff @(posedge clk_sys) begin
    r_dl_d <= ioctl_download;
    if (reset) begin
      r_state <= IDLE;
      r_wait  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (ioctl_download && !r_dl_d) begin
            r_addr  <= '0;
            r_pop   <= 2'b11;
            r_sgx   <= (ioctl_index[4:0] == SGX_IDX);
            r_state <= WAIT_WR;
          end
        end
        WAIT_WR: begin
          if (ioctl_wr) begin
            r_req   <= ~r_req;
            r_wait  <= 1'b1;
            r_pop   <= r_pop & ~w_clr;
            r_state <= WAIT_ACK;
          end else if (!ioctl_download) begin
            r_state <= IDLE;
          end
        end
        WAIT_ACK: begin
          if ((r_req == ack_dd) && (r_req == ack_sd)) begin
            r_wait  <= 1'b0;
            r_addr  <= r_addr + AW'(2);
            r_state <= ioctl_download ? WAIT_WR : IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ioctl_wait = r_wait;
  assign wr_addr    = r_addr;
  assign wr_req     = r_req;
  assign sgx        = r_sgx;
  assign rom_size   = r_addr[23:16];
  assign hdr        = r_addr[9];
  // Files too short to reach the first signature line leave both flags set.
  assign populous   = r_pop[r_addr[9]] & (r_addr >= AW'(16'h1F30));

endmodule

// File: tb/tb_pce_rom_loader.sv
// Bench for pce_rom_loader: scoreboarded write stream, delayed toggle acks,
// swap vector table and Populous / SuperGrafx / reset corner sequences.
module tb_pce_rom_loader;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b0;
  logic        ioctl_download = 1'b0;
  logic [7:0]  ioctl_index = '0;
  logic        ioctl_wr = 1'b0;
  logic [15:0] ioctl_dout = '0;
  logic        swap = 1'b0;
  logic        ioctl_wait, wr_req, populous, sgx, hdr, ack_dd, ack_sd;
  logic [23:0] wr_addr;
  logic [15:0] wr_data;
  logic [7:0]  rom_size;

  always #5 clk_sys = ~clk_sys;

  pce_rom_loader #(.AW(24), .SGX_IDX(5'd2)) dut (
    .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download),
    .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_dout(ioctl_dout),
    .ioctl_wait(ioctl_wait), .swap(swap), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_req(wr_req), .ack_dd(ack_dd), .ack_sd(ack_sd), .rom_size(rom_size),
    .hdr(hdr), .populous(populous), .sgx(sgx)
  );

  // Controller model: each ack mirrors wr_req after a programmable delay.
  int unsigned dd_lat = 0, sd_lat = 0;
  logic [31:0] req_hist = '0;
  always @(posedge clk_sys) req_hist <= {req_hist[30:0], wr_req};
  assign ack_dd = (dd_lat == 0) ? wr_req : req_hist[dd_lat-1];
  assign ack_sd = (sd_lat == 0) ? wr_req : req_hist[sd_lat-1];

  int unsigned cyc = 0;
  always @(posedge clk_sys) cyc++;

  int vectors = 0, miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct { logic [23:0] addr; logic [15:0] data; } wr_t;
  wr_t         sb_q[$];
  bit          sb_en = 1'b0;
  logic        last_req = 1'b0;
  int unsigned toggles = 0;

  always @(negedge clk_sys) begin
    wr_t e;
    if (wr_req !== last_req) begin
      last_req = wr_req;
      toggles++;
      if (sb_en) begin
        if (sb_q.size() == 0) check("unexpected_req", 32'd1, 32'd0);
        else begin
          e = sb_q.pop_front();
          check("sb_addr", 32'(wr_addr), 32'(e.addr));
          check("sb_data", 32'(wr_data), 32'(e.data));
        end
      end
    end
  end

  logic [23:0] mdl_addr = '0;
  int unsigned last_wait = 0;

  // Called at posedge+1; returns at posedge+1 after ioctl_wait drops.
  task automatic hps_write(input logic [15:0] d, input logic sw, input logic [15:0] exp_d,
                           input int unsigned inject_at);
    wr_t e;
    int unsigned c0;
    ioctl_dout = d;
    swap = sw;
    ioctl_wr = 1'b1;
    if (sb_en) begin
      e.addr = mdl_addr;
      e.data = exp_d;
      sb_q.push_back(e);
    end
    @(posedge clk_sys); #1;
    ioctl_wr = 1'b0;
    c0 = cyc;
    if (sb_en) check("wait_rise", 32'(ioctl_wait), 32'd1);
    while (ioctl_wait && (cyc - c0) < 200) begin
      ioctl_wr = (inject_at != 0) && ((cyc - c0) == inject_at);
      @(posedge clk_sys); #1;
    end
    ioctl_wr = 1'b0;
    if (ioctl_wait) check("wait_timeout", 32'd1, 32'd0);
    last_wait = cyc - c0;
    mdl_addr += 24'd2;
  endtask

  task automatic start_dl(input logic [7:0] idx);
    ioctl_index = idx;
    ioctl_download = 1'b1;
    mdl_addr = '0;
    @(posedge clk_sys); #1;
  endtask

  task automatic end_dl();
    ioctl_download = 1'b0;
    repeat (40) @(posedge clk_sys);
    #1;
  endtask

  task automatic load_image(input int unsigned nbytes, input int unsigned sig_base,
                            input logic exp_pop, input logic exp_hdr, input string tag);
    string s;
    logic [15:0] w;
    s = "POPULOUS";
    start_dl(8'h01);
    for (int unsigned a = 0; a < nbytes; a += 2) begin
      w = '0;
      if (a >= sig_base && a < sig_base + 8) w = {s[a - sig_base + 1], s[a - sig_base]};
      hps_write(w, 1'b0, w, 0);
    end
    end_dl();
    check({tag, "_addr"}, 32'(wr_addr), nbytes);
    check({tag, "_populous"}, 32'(populous), 32'(exp_pop));
    check({tag, "_hdr"}, 32'(hdr), 32'(exp_hdr));
    check({tag, "_rom_size"}, 32'(rom_size), nbytes >> 16);
  endtask

  typedef struct { logic sw; logic [15:0] dout; logic [15:0] exp; } vec_t;
  vec_t vecs[6];

  initial begin
    int unsigned t0;
    logic r0;
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int unsigned t0;
    logic        r0;
    vecs[0] = '{1'b0, 16'h1234, 16'h1234};
    vecs[1] = '{1'b1, 16'h0180, 16'h8001};
    vecs[2] = '{1'b1, 16'h1234, 16'h482C};
    vecs[3] = '{1'b1, 16'hF00F, 16'h0FF0};
    vecs[4] = '{1'b1, 16'h0102, 16'h8040};
    vecs[5] = '{1'b0, 16'hFFFF, 16'hFFFF};

    #1;
    check("pwr_addr", 32'(wr_addr), 32'd0);
    check("pwr_req", 32'(wr_req), 32'd0);
    check("pwr_wait", 32'(ioctl_wait), 32'd0);
    check("pwr_sgx", 32'(sgx), 32'd0);
    check("pwr_populous", 32'(populous), 32'd0);
    @(posedge clk_sys); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk_sys);
    #1 reset = 1'b0;
    check("rst_wait", 32'(ioctl_wait), 32'd0);
    sb_en = 1'b1;

    // Four words with 3-cycle acks
    dd_lat = 3; sd_lat = 3;
    start_dl(8'h00);
    check("t1_addr0", 32'(wr_addr), 32'd0);
    t0 = toggles;
    for (int unsigned i = 0; i < 4; i++) begin
      hps_write(16'(16'h1000 + i), 1'b0, 16'(16'h1000 + i), 0);
      check($sformatf("t1_wait_cycles%0d", i), last_wait, 32'd4);
    end
    check("t1_addr_end", 32'(wr_addr), 32'd8);
    check("t1_toggles", toggles - t0, 32'd4);
    end_dl();
    check("t1_short_populous", 32'(populous), 32'd0);

    // Late sdram ack, plus a stray ioctl_wr while waiting
    dd_lat = 0; sd_lat = 20;
    start_dl(8'h00);
    t0 = toggles;
    hps_write(16'hBEEF, 1'b0, 16'hBEEF, 5);
    check("t2_wait_cycles", last_wait, 32'd21);
    check("t2_toggles", toggles - t0, 32'd1);
    check("t2_addr", 32'(wr_addr), 32'd2);
    end_dl();

    // Swap table
    dd_lat = 0; sd_lat = 0;
    start_dl(8'h00);
    foreach (vecs[i]) begin
      hps_write(vecs[i].dout, vecs[i].sw, vecs[i].exp, 0);
      check($sformatf("t4_wait%0d", i), last_wait, 32'd1);
    end
    end_dl();

    // Rise coinciding with ioctl_wr drops that write
    r0 = wr_req;
    ioctl_index = 8'h00;
    ioctl_download = 1'b1;
    ioctl_wr = 1'b1;
    @(posedge clk_sys); #1;
    ioctl_wr = 1'b0;
    mdl_addr = '0;
    @(posedge clk_sys); #1;
    check("rise_wr_req", 32'(wr_req), 32'(r0));
    check("rise_wait", 32'(ioctl_wait), 32'd0);
    check("rise_addr", 32'(wr_addr), 32'd0);
    hps_write(16'h5A5A, 1'b0, 16'h5A5A, 0);
    end_dl();

    // SuperGrafx flag
    start_dl(8'h02);
    check("sgx_idx2", 32'(sgx), 32'd1);
    hps_write(16'h0001, 1'b0, 16'h0001, 0);
    end_dl();
    start_dl(8'h01);
    check("sgx_idx1", 32'(sgx), 32'd0);
    check("sgx_addr0", 32'(wr_addr), 32'd0);
    end_dl();
    start_dl(8'h22);
    check("sgx_idx22", 32'(sgx), 32'd1);
    end_dl();

    // Reset while a write is outstanding
    dd_lat = 0; sd_lat = 20;
    start_dl(8'h02);
    hps_write(16'h0000, 1'b0, 16'h0000, 0);
    begin
      wr_t e;
      e.addr = mdl_addr;
      e.data = 16'h7777;
      sb_q.push_back(e);
    end
    ioctl_dout = 16'h7777;
    ioctl_wr = 1'b1;
    @(posedge clk_sys); #1;
    ioctl_wr = 1'b0;
    repeat (3) @(posedge clk_sys);
    #1 check("t6_wait_before", 32'(ioctl_wait), 32'd1);
    reset = 1'b1;
    @(posedge clk_sys); #1;
    reset = 1'b0;
    check("t6_wait_after", 32'(ioctl_wait), 32'd0);
    check("t6_addr_kept", 32'(wr_addr), 32'd2);
    check("t6_sgx_kept", 32'(sgx), 32'd1);
    repeat (30) @(posedge clk_sys);
    #1 check("t6_addr_idle", 32'(wr_addr), 32'd2);
    r0 = wr_req;
    ioctl_wr = 1'b1;
    @(posedge clk_sys); #1;
    ioctl_wr = 1'b0;
    repeat (2) @(posedge clk_sys);
    #1 check("t6_idle_ignores_wr", 32'(wr_req), 32'(r0));
    check("t6_idle_wait", 32'(ioctl_wait), 32'd0);
    end_dl();
    check("sb_drained", sb_q.size(), 32'd0);

    // Populous detection on full images
    sb_en = 1'b0;
    dd_lat = 0; sd_lat = 0;
    load_image(32'h2400, 32'h1F26, 1'b1, 1'b0, "pop_nohdr");
    load_image(32'h2600, 32'h2126, 1'b1, 1'b1, "pop_hdr");
    load_image(32'h2400, 32'h2126, 1'b0, 1'b0, "pop_wrongline");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
